// File: rtl/bcd_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_counter_pkg
// Shared definitions for the multi-digit BCD counter.
//   BCD_W        : width of one BCD decade (4 bits)
//   BCD_MAX      : largest legal decade value (9)
//   BCD_MIN      : smallest legal decade value (0)
//   bcd_digit_t  : one BCD decade
//   bcd_is_legal : 1 when a 4-bit value is a legal decimal digit (0..9)
// -----------------------------------------------------------------------------
package bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = '0;

  function automatic logic bcd_is_legal(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One synchronous BCD decade (0..9) with up/down stepping and parallel load.
// Ports:
//   clk      : clock, state updates on rising edge
//   reset    : asynchronous active-high reset, clears the digit to 0
//   en_in    : step enable for this decade (already includes lower carries)
//   up       : 1 = increment, 0 = decrement
//   load     : synchronous load, overrides en_in
//   d_in     : load value; values above 9 are loaded as 0
//   q        : registered digit value, always 0..9
//   co       : carry/borrow out: en_in and digit at 9 (up) or 0 (down)
//   d_in_bad : 1 when d_in is not a legal decimal digit
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_in,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t d_in,
  output bcd_digit_t q,
  output logic       co,
  output logic       d_in_bad
);

  bcd_digit_t q_q;
  bcd_digit_t q_d;
  logic       at_bound;

  always_comb begin
    at_bound = up ? (q_q == BCD_MAX) : (q_q == BCD_MIN);
    co       = en_in & at_bound;
    d_in_bad = ~bcd_is_legal(d_in);

    q_d = q_q;
    if (load) begin
      q_d = d_in_bad ? BCD_MIN : d_in;
    end else if (en_in) begin
      if (up) begin
        // >= rather than == so a corrupted state can never escape 0..9
        q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + bcd_digit_t'(1);
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - bcd_digit_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// -----------------------------------------------------------------------------
// multi_digit_bcd_counter
// Synchronous up/down BCD counter of DIGITS decades (1..8) with parallel load,
// illegal-digit load sanitising and a combinational terminal-count output.
// Parameters:
//   DIGITS   : number of BCD decades, 1..8
// Ports:
//   clk      : single clock, all state updates on rising edge
//   reset    : asynchronous active-high reset (count = 0, load_err = 0)
//   en       : count enable
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous parallel load, priority over en
//   data_in  : BCD load value, digit k in bits [4k+3:4k]
//   count    : registered BCD count
//   tc       : terminal count, en & up & all-9 | en & ~up & all-0
//   load_err : registered one-cycle flag, a load contained a digit > 9
// Build option:
//   BCD_SATURATE_EN : when defined, enabled counting holds at 99..9 (up) or
//                     00..0 (down) instead of wrapping; tc is unchanged.
// -----------------------------------------------------------------------------
module multi_digit_bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] data_in,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    tc,
  output logic                    load_err
);

`ifdef BCD_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [BCD_W*DIGITS-1:0] digit_d;
  logic [DIGITS-1:0]       digit_bad;
  logic                    digit_load;
  logic                    top_co;
  logic                    load_err_q;
  logic                    load_err_d;

  // Saturation is a self-reload of the current count whenever the whole
  // counter would wrap; keeps the carry chain free of any feedback from tc.
  always_comb begin
    digit_load = load | (SAT_EN & top_co);
    digit_d    = load ? data_in : count;
    load_err_d = load & (|digit_bad);
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic en_in;
    logic co;

    // en_in of digit k is en AND all lower carry-outs; the previous stage's
    // en_in already holds the AND of everything below it.
    if (k == 0) begin : g_first
      assign en_in = en;
    end else begin : g_chain
      assign en_in = g_digit[k-1].en_in & g_digit[k-1].co;
    end

    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .en_in    (en_in),
      .up       (up),
      .load     (digit_load),
      .d_in     (digit_d[k*BCD_W +: BCD_W]),
      .q        (count[k*BCD_W +: BCD_W]),
      .co       (co),
      .d_in_bad (digit_bad[k])
    );
  end

  // Top carry-out = en & every digit at its direction's boundary, which is
  // exactly the terminal-count condition.
  assign top_co = g_digit[DIGITS-1].co;
  assign tc     = top_co;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_bcd_counter
// Self-checking bench for multi_digit_bcd_counter (DIGITS = 2). The reference
// model holds the count as a plain integer 0..10^DIGITS-1 and converts to BCD
// only for comparison. Honors BCD_SATURATE_EN like the design.
// -----------------------------------------------------------------------------
module tb_multi_digit_bcd_counter;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = 4 * DIGITS;

`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] data_in;
  logic [W-1:0] count;
  logic         tc;
  logic         load_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned mval;
  bit          merr;
  int unsigned max_v;

  always #5 clk = ~clk;

  multi_digit_bcd_counter #(
    .DIGITS(DIGITS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .data_in  (data_in),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  function automatic int unsigned calc_max();
    int unsigned r;
    r = 1;
    for (int i = 0; i < int'(DIGITS); i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check tc before the edge, advance the
  // model on the edge, then check count and load_err just after it.
  task automatic drive_cycle(input bit ien, input bit iup, input bit iload,
                             input logic [W-1:0] idata);
    int unsigned v;
    int unsigned mult;
    int unsigned d;
    bit          err;
    bit          exp_tc;
    en      = ien;
    up      = iup;
    load    = iload;
    data_in = idata;
    #1;
    exp_tc = ien && (iup ? (mval == max_v) : (mval == 0));
    check_eq("tc", 32'(tc), 32'(exp_tc));
    @(posedge clk);
    if (iload) begin
      v    = 0;
      mult = 1;
      err  = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        d = 32'(idata[4*i +: 4]);
        if (d > 9) begin
          err = 1'b1;
          d   = 0;
        end
        v    = v + d * mult;
        mult = mult * 10;
      end
      mval = v;
      merr = err;
    end else begin
      merr = 1'b0;
      if (ien) begin
        if (iup) mval = (mval == max_v) ? (SAT ? max_v : 0) : mval + 1;
        else     mval = (mval == 0) ? (SAT ? 0 : max_v) : mval - 1;
      end
    end
    #1;
    check_eq("count", 32'(count), 32'(to_bcd(mval)));
    check_eq("load_err", 32'(load_err), 32'(merr));
  endtask

  initial begin
    logic [W-1:0] rdata;
    reset   = 1'b1;
    en      = 1'b0;
    up      = 1'b0;
    load    = 1'b0;
    data_in = '0;
    max_v   = calc_max();
    mval    = 0;
    merr    = 1'b0;

    // reset takes effect before any clock edge
    #3;
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_load_err", 32'(load_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-count at 37, observed before the next edge
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h36);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("count_37", 32'(count), 32'h37);
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_count", 32'(count), 32'h0);
    check_eq("async_rst_load_err", 32'(load_err), 32'h0);
    mval = 0;
    merr = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // reset during a pending load discards the load and clears load_err
    drive_cycle(1'b0, 1'b0, 1'b1, 8'hA7);
    en      = 1'b1;
    up      = 1'b1;
    load    = 1'b1;
    data_in = 8'h55;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_load_count", 32'(count), 32'h0);
    check_eq("rst_mid_load_err", 32'(load_err), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_held_count", 32'(count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    load  = 1'b0;
    mval  = 0;
    merr  = 1'b0;

    // 48 + 20 increments = 68, no terminal count on the way
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h48);
    repeat (20) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("up20_end", 32'(count), 32'h68);

    // increment across the top
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h98);
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("wrap_up_end", 32'(count), SAT ? 32'h99 : 32'h01);

    // decrement across the bottom
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h01);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check_eq("wrap_dn_end", 32'(count), SAT ? 32'h00 : 32'h98);

    // illegal digit load, one-cycle error pulse
    drive_cycle(1'b0, 1'b0, 1'b1, 8'hA7);
    check_eq("illegal_load", 32'(count), 32'h07);
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 1'b1, 8'hFF);

    // load beats en
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h55);
    drive_cycle(1'b1, 1'b1, 1'b1, 8'h20);
    check_eq("load_over_en", 32'(count), 32'h20);

    // random mix of loads, holds and direction changes
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) rdata = W'($urandom);
      else if ($urandom_range(0, 1) == 0) rdata = to_bcd($urandom_range(0, 1) ? max_v : 0);
      else rdata = to_bcd($urandom_range(0, max_v));
      drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 11) == 0), rdata);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
